// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg
//   Shared definitions for the fractal_sync tx response path.
//   - fsync_rsp_default_t : default response layout used when the scheduler is
//                           instantiated without an explicit response type. Any
//                           replacement type must be packed and must provide
//                           1-bit fields named wake and grant.
//   - idx_w()             : index width for an N-entry source vector,
//                           max(1, $clog2(n)), so a single source still has a
//                           1-bit pointer.
package fractal_sync_pkg;

    typedef struct packed {
        logic [5:0] id;
        logic       grant;
        logic       wake;
    } fsync_rsp_default_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fractal_sync_rr_pick.sv
// fractal_sync_rr_pick
//   Combinational masked round-robin picker. Grants the first requester at or
//   above the pointer; if there is none, it wraps around and grants the lowest
//   requester.
//   Ports:
//     req_i  in   N      request vector
//     ptr_i  in   IDX_W  round-robin pointer (highest-priority index)
//     gnt_o  out  N      one-hot grant, zero when there is no request
//     idx_o  out  IDX_W  index of the granted requester, 0 when there is none
//     any_o  out  1      at least one request is present
module fractal_sync_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        // First pass: requesters in the upper, unmasked part [ptr, N-1].
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
        // Second pass: wrap around to the lowest requester.
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/fractal_sync_tx_sched.sv
// fractal_sync_tx_sched
//   Drains the fall-through response FIFOs of several tx datapaths onto one
//   shared response channel. Each cycle it picks at most one non-empty source
//   (round-robin, with optional preference for grant heads), pops that source,
//   and registers its head into a 1-deep valid/ready output stage.
//   Ports:
//     clk_i        in   1              clock
//     rst_i        in   1              synchronous reset, active-high
//     en_i         in   1              enable; 0 stops new pops only
//     src_empty_i  in   N_SRC          FIFO empty flags
//     src_rsp_i    in   N_SRC x rsp    FIFO heads
//     src_pop_o    out  N_SRC          FIFO pops, one-hot or zero
//     rsp_valid_o  out  1              output response valid
//     rsp_o        out  rsp            output response
//     rsp_ready_i  in   1              downstream accepts rsp_o
//     busy_o       out  1              output stage occupied
//     sent_cnt_o   out  CNT_W          saturating count of accepted responses
//   The output stage has two implicit states held in valid_q:
//     EMPTY (valid_q=0): goes FULL on a pop.
//     FULL  (valid_q=1): goes EMPTY on ready without a pop; stays FULL otherwise.
module fractal_sync_tx_sched
    import fractal_sync_pkg::*;
#(
    parameter type  fsync_rsp_t = fsync_rsp_default_t,
    parameter int   N_SRC       = 2,
    parameter logic PRIO_GRANT  = 1'b1,
    parameter int   CNT_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [N_SRC-1:0]       src_empty_i,
    input  fsync_rsp_t [N_SRC-1:0] src_rsp_i,
    output logic [N_SRC-1:0]       src_pop_o,
    output logic                   rsp_valid_o,
    output fsync_rsp_t             rsp_o,
    input  logic                   rsp_ready_i,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       sent_cnt_o
);

    localparam int IDX_W = idx_w(N_SRC);

    logic [IDX_W-1:0] rr_q;
    logic             valid_q;
    fsync_rsp_t       rsp_q;
    logic [CNT_W-1:0] sent_cnt_q;

    logic [N_SRC-1:0] nonempty;
    logic [N_SRC-1:0] grant_req;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] gnt;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] next_rr;
    logic             any_cand;
    logic             slot_free;
    logic             can_pop;
    logic             accept;

    always_comb begin
        nonempty = ~src_empty_i;
        for (int i = 0; i < N_SRC; i++) begin
            grant_req[i] = nonempty[i] & src_rsp_i[i].grant;
        end
        // Grant heads win only when at least one is present; otherwise every
        // non-empty source competes.
        cand = (PRIO_GRANT && (|grant_req)) ? grant_req : nonempty;
    end

    fractal_sync_rr_pick #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (cand),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (any_cand)
    );

    assign slot_free = !valid_q | rsp_ready_i;
    assign can_pop   = en_i & slot_free & any_cand & !rst_i;
    assign accept    = valid_q & rsp_ready_i;
    assign next_rr   = (win_idx == IDX_W'(N_SRC - 1)) ? '0 : win_idx + IDX_W'(1);

    assign src_pop_o = can_pop ? gnt : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            rsp_q      <= '0;
            rr_q       <= '0;
            sent_cnt_q <= '0;
        end else begin
            if (accept && (sent_cnt_q != '1)) begin
                sent_cnt_q <= sent_cnt_q + CNT_W'(1);
            end
            if (can_pop) begin
                rsp_q   <= src_rsp_i[win_idx];
                valid_q <= 1'b1;
                rr_q    <= next_rr;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_o       = rsp_q;
    assign busy_o      = valid_q;
    assign sent_cnt_o  = sent_cnt_q;

endmodule
